key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Upstream stage of the 10-key priority encoder (key_encoder).
- Takes raw, bouncing, active-low key lines from the keypad pins and produces a clean, registered active-low S_n bus that feeds the encoder's S_n input directly.
- Also emits a one-cycle press strobe per key for event-driven consumers.

Parameters:
- N_KEYS, 10, number of key lines; must match the encoder's S_n width.
- DEB_CYCLES, 20, consecutive cycles a differing level must persist before acceptance; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_raw_n  input  N_KEYS  raw key levels; 0 = pressed; may bounce; asynchronous to clk.
- S_n  output  N_KEYS  debounced key levels; 0 = pressed; registered; connects to key_encoder.S_n.
- key_press  output  N_KEYS  one-cycle pulse per key on debounced press (S_n bit 1->0).
- any_pressed  output  1  registered; 1 when any S_n bit is 0.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - S_n = all 1s; key_press = 0; any_pressed = 0.
  - All counters = 0; synchronizer flops = all 1s.
- Per key i, fully independent. Let samp = the sampled input: key_raw_n[i], or its synchronized copy (see Optional Feature).
  - Counter cnt_i has width $clog2(DEB_CYCLES+1).
  - Each cycle:
    - samp == S_n[i] -> cnt_i <= 0.
    - samp != S_n[i] and cnt_i < DEB_CYCLES-1 -> cnt_i <= cnt_i+1.
    - samp != S_n[i] and cnt_i == DEB_CYCLES-1 -> S_n[i] <= samp; cnt_i <= 0.
  - Any single matching sample restarts the count, so bounces shorter than DEB_CYCLES are rejected.
  - Counter never exceeds DEB_CYCLES-1; no wrap-around.
- Latency: a level change held steady from sample cycle k appears on S_n[i] after the clock edge ending cycle k+DEB_CYCLES-1, i.e. DEB_CYCLES cycles. With DEB_CYCLES=1, S_n follows samp with 1-cycle delay.
- key_press[i]:
  - Registered; high for exactly the one cycle in which S_n[i] first reads 0 after having been 1.
  - No pulse on release (0->1).
- any_pressed:
  - Registered from the next-state of S_n, so it is cycle-aligned with S_n.
  - Equals ~&S_n.
- Simultaneous events:
  - Multiple keys may settle in the same cycle; each gets its own key_press pulse.
  - Priority resolution is the encoder's job, not this block's.
- Reset mid-debounce: all partial counts are discarded; after release of reset the keys restart from the released state. A key held low through reset produces a press after DEB_CYCLES (+ sync latency) cycles.
- Held key: S_n stays 0 indefinitely; no repeated key_press.

Optional Feature:
- Macro: KEY_DEBOUNCER_SYNC_EN.
- Defined:
  - A 2-flop synchronizer per key (reset to 1) sits ahead of the debounce logic; samp = second flop.
  - Total input-to-S_n latency = DEB_CYCLES+2.
- Undefined:
  - samp = key_raw_n directly; latency = DEB_CYCLES.
  - The integrator must guarantee key_raw_n is already synchronous to clk.

Decomposition:
- Package key_pkg:
  - localparam N_KEYS_DEF = 10.
  - localparam DEB_CYCLES_DEF = 20.
  - typedef logic [N_KEYS_DEF-1:0] key_vec_t, shared with key_encoder.
- Sub-module key_debounce_bit:
  - Contains one key's optional synchronizer, counter, stable flop and press detect.
  - Instantiated N_KEYS times via generate.
  - Top level adds only the any_pressed register.

Test Plan (DEB_CYCLES=4 unless noted, sync macro undefined):
- Reset then key_raw_n=10'h3FF for 10 cycles -> S_n=10'h3FF, key_press=0, any_pressed=0 throughout.
- key_raw_n[3]=0 held from cycle 10 -> S_n=10'h3F7 from cycle 14; key_press=10'h008 for exactly cycle 14; any_pressed=1 from cycle 14.
- Bounce on key 5: 0,0,0,1,0,0,0,1 repeating -> S_n[5] stays 1 and key_press[5] never asserts. Then hold 0 for 4 cycles -> S_n[5]=0 with one key_press[5] pulse.
- Keys 0 and 9 go low in the same cycle -> both S_n bits fall in the same cycle; key_press=10'h201 for one cycle. Release both -> S_n returns to 10'h3FF 4 cycles later with no pulses.
- rst_n asserted while key 2 is at count 2 -> outputs go to reset values immediately, without waiting for a clock edge. Key 2 held low across reset release -> S_n[2]=0 exactly 4 cycles after rst_n rises.
- KEY_DEBOUNCER_SYNC_EN defined, DEB_CYCLES=1 -> a key_raw_n[7] falling edge appears on S_n[7] exactly 3 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared keypad constants and types for the debouncer and the key_encoder.
package key_pkg;

    localparam int N_KEYS_DEF     = 10;
    localparam int DEB_CYCLES_DEF = 20;

    typedef logic [N_KEYS_DEF-1:0] key_vec_t;

    // Counter width able to hold 0 .. deb inclusive.
    function automatic int cnt_width(input int deb);
        return $clog2(deb + 1);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key line: optional 2-flop synchronizer (KEY_DEBOUNCER_SYNC_EN),
// persistence counter, debounced level flop and press-edge strobe.
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic stable_n,
    output logic stable_n_next,
    output logic press
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic samp_s;

`ifdef KEY_DEBOUNCER_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_raw_n};
        end
    end

    assign samp_s = sync_r[1];
`else
    assign samp_s = key_raw_n;
`endif

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          stable_r;
    logic          stable_nxt_s;
    logic          press_r;
    logic          press_nxt_s;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        cnt_nxt_s    = CNT_ZERO;
        stable_nxt_s = stable_r;
        if (samp_s == stable_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            stable_nxt_s = samp_s;
            cnt_nxt_s    = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
        press_nxt_s = stable_r & ~stable_nxt_s;
    end

    // Counter, debounced level and press strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b1;
            press_r  <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            press_r  <= press_nxt_s;
        end
    end

    assign stable_n      = stable_r;
    assign stable_n_next = stable_nxt_s;
    assign press         = press_r;

endmodule

// File: rtl/key_debouncer.sv
// Keypad debouncer feeding key_encoder.S_n; one key_debounce_bit per line.
// Optional input synchronizer enabled by defining KEY_DEBOUNCER_SYNC_EN.
module key_debouncer
    import key_pkg::*;
#(
    parameter int N_KEYS     = N_KEYS_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] S_n,
    output logic [N_KEYS-1:0] key_press,
    output logic              any_pressed
);

    logic [N_KEYS-1:0] stable_next_s;
    logic              any_pressed_r;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_bit (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_raw_n    (key_raw_n[i]),
            .stable_n     (S_n[i]),
            .stable_n_next(stable_next_s[i]),
            .press        (key_press[i])
        );
    end

    // Built from next-state so it lines up with S_n in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed_r <= 1'b0;
        end else begin
            any_pressed_r <= ~&stable_next_s;
        end
    end

    assign any_pressed = any_pressed_r;

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized self-checking bench for key_debouncer (DEB_CYCLES=4) with a
// sliding-window reference model, plus a DEB_CYCLES=1 instance for latency.
module tb_key_debouncer;

    localparam int TB_DEB = 4;
`ifdef KEY_DEBOUNCER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] key_raw_n = 10'h3FF;
    logic [9:0] S_n, key_press;
    logic       any_pressed;
    logic [9:0] key_raw_b = 10'h3FF;
    logic [9:0] s_n_b, press_b;
    logic       any_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debouncer #(.N_KEYS(10), .DEB_CYCLES(TB_DEB)) dut (
        .clk(clk), .rst_n(rst_n), .key_raw_n(key_raw_n),
        .S_n(S_n), .key_press(key_press), .any_pressed(any_pressed)
    );

    key_debouncer #(.N_KEYS(10), .DEB_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_raw_n(key_raw_b),
        .S_n(s_n_b), .key_press(press_b), .any_pressed(any_b)
    );

    // Reference: a key flips once its last TB_DEB samples all disagree with it.
    logic [9:0][TB_DEB-1:0] win_r;
    logic [9:0] m_s, m_press, d1_r, d2_r, samp;
    logic       m_any;

    assign samp = (SYNC_LAT == 2) ? d2_r : key_raw_n;

    function automatic logic [9:0][TB_DEB-1:0] shift_in(input logic [9:0][TB_DEB-1:0] w,
                                                       input logic [9:0] s);
        logic [9:0][TB_DEB-1:0] r;
        for (int i = 0; i < 10; i++) r[i] = {w[i][TB_DEB-2:0], s[i]};
        return r;
    endfunction

    function automatic logic [9:0] settle(input logic [9:0][TB_DEB-1:0] w, input logic [9:0] cur);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = (w[i] == {TB_DEB{~cur[i]}}) ? ~cur[i] : cur[i];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r   <= {10*TB_DEB{1'b1}};
            m_s     <= 10'h3FF;
            m_press <= 10'h000;
            m_any   <= 1'b0;
            d1_r    <= 10'h3FF;
            d2_r    <= 10'h3FF;
        end else begin
            d1_r    <= key_raw_n;
            d2_r    <= d1_r;
            win_r   <= shift_in(win_r, samp);
            m_s     <= settle(shift_in(win_r, samp), m_s);
            m_press <= m_s & ~settle(shift_in(win_r, samp), m_s);
            m_any   <= ~&settle(shift_in(win_r, samp), m_s);
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({S_n, key_press, any_pressed} !== {10'h3FF, 10'h000, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got S_n=%h press=%h any=%b want 3ff/000/0", S_n, key_press, any_pressed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({S_n, key_press, any_pressed} !== {10'h3FF, 10'h000, 1'b0}) begin
                failures++;
                $display("FAIL idle c=%0d got S_n=%h press=%h any=%b want 3ff/000/0", c, S_n, key_press, any_pressed);
            end
        end
    endtask

    task automatic test_single_press();
        int lat = 0;
        int pulses = 0;
        key_raw_n = 10'h3F7;
        while (lat < 20 && S_n[3] !== 1'b0) begin
            @(negedge clk);
            lat++;
            pulses += int'(key_press[3]);
            checks++;
            if ({S_n, key_press, any_pressed} !== {m_s, m_press, m_any}) begin
                failures++;
                $display("FAIL press_model got %h/%h/%b want %h/%h/%b", S_n, key_press, any_pressed, m_s, m_press, m_any);
            end
        end
        checks++;
        if (lat != TB_DEB + SYNC_LAT || key_press !== 10'h008 || any_pressed !== 1'b1 || S_n !== 10'h3F7) begin
            failures++;
            $display("FAIL press_latency got lat=%0d S_n=%h press=%h any=%b want lat=%0d 3f7/008/1",
                     lat, S_n, key_press, any_pressed, TB_DEB + SYNC_LAT);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pulses += int'(key_press[3]);
        end
        checks++;
        if (pulses != 1 || S_n !== 10'h3F7) begin
            failures++;
            $display("FAIL press_held got pulses=%0d S_n=%h want 1/3f7", pulses, S_n);
        end
        key_raw_n = 10'h3FF;
        repeat (TB_DEB + SYNC_LAT + 2) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic [7:0] pat = 8'b1000_1000;
        int pulses = 0;
        for (int c = 0; c < 24; c++) begin
            key_raw_n[5] = pat[c % 8];
            @(negedge clk);
            pulses += int'(key_press[5]);
            checks++;
            if ({S_n, key_press, any_pressed} !== {m_s, m_press, m_any} || S_n[5] !== 1'b1) begin
                failures++;
                $display("FAIL bounce got %h/%h/%b want %h/%h/%b", S_n, key_press, any_pressed, m_s, m_press, m_any);
            end
        end
        key_raw_n[5] = 1'b0;
        repeat (TB_DEB + SYNC_LAT + 2) begin
            @(negedge clk);
            pulses += int'(key_press[5]);
        end
        checks++;
        if (pulses != 1 || S_n !== 10'h3DF) begin
            failures++;
            $display("FAIL bounce_settle got pulses=%0d S_n=%h want 1/3df", pulses, S_n);
        end
        key_raw_n = 10'h3FF;
        repeat (TB_DEB + SYNC_LAT + 2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int seen = 0;
        int rel_pulses = 0;
        key_raw_n = 10'h1FE;
        repeat (TB_DEB + SYNC_LAT + 2) begin
            @(negedge clk);
            seen += int'(key_press == 10'h201);
            checks++;
            if ({S_n, key_press, any_pressed} !== {m_s, m_press, m_any} || (S_n[0] !== S_n[9])) begin
                failures++;
                $display("FAIL simul got %h/%h/%b want %h/%h/%b", S_n, key_press, any_pressed, m_s, m_press, m_any);
            end
        end
        checks++;
        if (seen != 1 || S_n !== 10'h1FE) begin
            failures++;
            $display("FAIL simul_pulse got pulses=%0d S_n=%h want 1/1fe", seen, S_n);
        end
        key_raw_n = 10'h3FF;
        repeat (TB_DEB + SYNC_LAT + 2) begin
            @(negedge clk);
            rel_pulses += int'(key_press != 10'h000);
        end
        checks++;
        if (rel_pulses != 0 || S_n !== 10'h3FF || any_pressed !== 1'b0) begin
            failures++;
            $display("FAIL simul_release got pulses=%0d S_n=%h any=%b want 0/3ff/0", rel_pulses, S_n, any_pressed);
        end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        key_raw_n = 10'h3FB;
        repeat (2 + SYNC_LAT) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({S_n, key_press, any_pressed} !== {10'h3FF, 10'h000, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got %h/%h/%b want 3ff/000/0", S_n, key_press, any_pressed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        while (lat < 20 && S_n[2] !== 1'b0) begin
            @(negedge clk);
            lat++;
            checks++;
            if ({S_n, key_press, any_pressed} !== {m_s, m_press, m_any}) begin
                failures++;
                $display("FAIL reset_model got %h/%h/%b want %h/%h/%b", S_n, key_press, any_pressed, m_s, m_press, m_any);
            end
        end
        checks++;
        if (lat != TB_DEB + SYNC_LAT || key_press !== 10'h004) begin
            failures++;
            $display("FAIL reset_relatch got lat=%0d press=%h want %0d/004", lat, key_press, TB_DEB + SYNC_LAT);
        end
        key_raw_n = 10'h3FF;
        repeat (TB_DEB + SYNC_LAT + 2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [9:0] lvl = 10'h3FF;
        logic [9:0] glitch;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 11) == 0) lvl[i] = ~lvl[i];
                glitch[i] = ($urandom_range(0, 7) == 0);
            end
            key_raw_n = lvl ^ glitch;
            @(negedge clk);
            checks++;
            if ({S_n, key_press, any_pressed} !== {m_s, m_press, m_any}) begin
                failures++;
                $display("FAIL random c=%0d got %h/%h/%b want %h/%h/%b", c, S_n, key_press, any_pressed, m_s, m_press, m_any);
            end
        end
        key_raw_n = 10'h3FF;
        repeat (TB_DEB + SYNC_LAT + 2) @(negedge clk);
    endtask

    task automatic test_sync_latency();
        int lat = 0;
        key_raw_b = 10'h37F;
        while (lat < 10 && s_n_b[7] !== 1'b0) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 1 + SYNC_LAT || press_b !== 10'h080 || any_b !== 1'b1) begin
            failures++;
            $display("FAIL deb1_latency got lat=%0d press=%h any=%b want %0d/080/1", lat, press_b, any_b, 1 + SYNC_LAT);
        end
        @(negedge clk);
        checks++;
        if (press_b !== 10'h000 || s_n_b !== 10'h37F) begin
            failures++;
            $display("FAIL deb1_held got press=%h S_n=%h want 000/37f", press_b, s_n_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        test_sync_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
